// File: rtl/rnn_matvec_sequencer.sv
// Sequences y = W*x through one shared MAC: per row COLS issue cycles + 1 drain, result valid (r+1)*(COLS+2) cycles after start.
// Backpressure: a result holds in OUT until out_ready; no addresses are issued and the accumulator is frozen meanwhile.
module rnn_matvec_sequencer #(
  parameter int ROWS = 4,
  parameter int COLS = 32,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int ACCW = 40,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] w_row,
  output logic [CW-1:0] w_col,
  input  logic [DW-1:0] w_data,
  output logic [CW-1:0] x_addr,
  input  logic [DW-1:0] x_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [DW-1:0] out_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, FIN} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          w_row_q, w_row_d;
  logic [CW-1:0]          w_col_q, w_col_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   out_valid_q, out_valid_d;
  logic [RW-1:0]          out_row_q, out_row_d;
  logic [DW-1:0]          out_data_q, out_data_d;

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_sum;
  logic signed [ACCW-1:0] shifted;
  logic [ACCW-DW:0]       shifted_hi;
  logic [DW-1:0]          sat_val;

  assign prod     = $signed(w_data) * $signed(x_data);
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  assign acc_sum  = acc_q + prod_ext;
  assign shifted  = acc_sum >>> FRAC;

  // The result fits in DW bits only when every bit above the DW-bit sign position agrees with it.
  assign shifted_hi = shifted[ACCW-1:DW-1];

  always_comb begin
    sat_val = shifted[DW-1:0];
    if (!((&shifted_hi) || !(|shifted_hi))) begin
      sat_val = shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    w_row_d     = w_row_q;
    w_col_d     = w_col_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          w_row_d = '0;
          w_col_d = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        // Read data lags the address by one cycle, so column 0 has nothing to add yet.
        if (w_col_q != '0) begin
          acc_d = acc_sum;
        end
        if (w_col_q == CW'(COLS - 1)) begin
          state_d = DRAIN;
        end else begin
          w_col_d = w_col_q + CW'(1);
        end
      end
      DRAIN: begin
        acc_d       = acc_sum;
        out_data_d  = sat_val;
        out_row_d   = w_row_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (w_row_q == RW'(ROWS - 1)) begin
            state_d = FIN;
          end else begin
            w_row_d = w_row_q + RW'(1);
            w_col_d = '0;
            acc_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_row_q     <= '0;
      w_col_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_row_q     <= w_row_d;
      w_col_q     <= w_col_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == OUT);
  assign done      = (state_q == FIN);
  assign w_row     = w_row_q;
  assign w_col     = w_col_q;
  assign x_addr    = w_col_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rnn_matvec_sequencer.sv
// Directed bench for rnn_matvec_sequencer: table of full products plus backpressure and abort sequences.
module tb_rnn_matvec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  w_row;
  logic [4:0]  w_col;
  logic [15:0] w_data;
  logic [4:0]  x_addr;
  logic [15:0] x_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_row;
  logic [15:0] out_data;

  rnn_matvec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_row(w_row), .w_col(w_col), .w_data(w_data), .x_addr(x_addr), .x_data(x_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] wmem [4][32];
  logic [15:0] xmem [32];

  // Synchronous read stores: data valid one cycle after the address.
  always @(posedge clk) begin
    w_data <= wmem[w_row][w_col];
    x_data <= xmem[x_addr];
  end

  typedef struct {
    string            nm;
    bit               deployed;
    logic [15:0]      wv;
    logic [15:0]      xv;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vt [5];
  int   n_chk = 0;
  int   n_err = 0;
  int   k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  // Deployed table: W[r][c] = (c-16)*kr + (c==1), kr = {1,2,-1,-3}; x[c] = 16*c.
  // Row sums 39680*kr + 16 -> >>>8 gives 155, 310, -155, -465.
  task automatic fill(input bit deployed, input logic [15:0] wv, input logic [15:0] xv);
    int kr [4];
    kr = '{1, 2, -1, -3};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 32; c++) begin
        if (deployed) wmem[r][c] = 16'((c - 16) * kr[r] + ((c == 1) ? 1 : 0));
        else          wmem[r][c] = wv;
      end
    end
    for (int c = 0; c < 32; c++) xmem[c] = deployed ? 16'(c * 16) : xv;
  endtask

  task automatic run_vec(input string nm, input logic [3:0][15:0] exp, input bit poke);
    int rows_seen;
    bit fin;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    k = 0;
    rows_seen = 0;
    fin = 1'b0;
    while (!fin && k < 400) begin
      tick();
      start = poke && (k == 5);
      if (k == 1) begin
        chk({nm, " busy@1"}, 32'(busy), 1);
        chk({nm, " w_col@1"}, 32'(w_col), 0);
      end
      if (out_valid) begin
        chk({nm, " valid cycle"}, k, (rows_seen + 1) * 34);
        chk({nm, " out_row"}, 32'(out_row), rows_seen & 3);
        chk({nm, " out_data"}, 32'(out_data), 32'(exp[rows_seen & 3]));
        rows_seen++;
      end
      if (done) begin
        chk({nm, " done cycle"}, k, 137);
        chk({nm, " busy at done"}, 32'(busy), 0);
        chk({nm, " rows seen"}, rows_seen, 4);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    chk({nm, " done seen"}, 32'(fin), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"ident",    1'b0, 16'h0100, 16'h0100, {4{16'h2000}}};
    vt[1] = '{"negsum",   1'b0, 16'hFFFF, 16'h0100, {4{16'hFFE0}}};
    vt[2] = '{"satpos",   1'b0, 16'h7FFF, 16'h7FFF, {4{16'h7FFF}}};
    vt[3] = '{"satneg",   1'b0, 16'h7FFF, 16'h8000, {4{16'h8000}}};
    vt[4] = '{"deployed", 1'b1, 16'h0000, 16'h0000, {16'hFE2F, 16'hFF65, 16'h0136, 16'h009B}};

    k = 0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    fill(1'b0, 16'h0100, 16'h0100);
    #23;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst w_row", 32'(w_row), 0);
    chk("rst w_col", 32'(w_col), 0);
    chk("rst out_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back runs: each start lands in the cycle right after FIN.
    for (int i = 0; i < 5; i++) begin
      fill(vt[i].deployed, vt[i].wv, vt[i].xv);
      run_vec(vt[i].nm, vt[i].exp, vt[i].deployed);
    end

    // Backpressure on row 1 for five cycles.
    fill(1'b0, 16'h0100, 16'h0100);
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    k = 0;
    tick();
    start = 1'b0;
    while (!out_valid && k < 100) tick();
    chk("bp row0 cycle", k, 34);
    out_ready = 1'b1;
    tick();
    chk("bp valid drop", 32'(out_valid), 0);
    out_ready = 1'b0;
    while (!out_valid && k < 200) tick();
    chk("bp row1 cycle", k, 68);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 32'(out_valid), 1);
      chk("bp hold data", 32'(out_data), 32'h2000);
      chk("bp hold row", 32'(out_row), 1);
      chk("bp hold w_row", 32'(w_row), 1);
      chk("bp hold w_col", 32'(w_col), 31);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp after hs valid", 32'(out_valid), 0);
    chk("bp row2 w_row", 32'(w_row), 2);
    chk("bp row2 w_col", 32'(w_col), 0);
    tick();
    chk("bp row2 w_col+1", 32'(w_col), 1);
    while (!done && k < 300) tick();
    chk("bp done cycle", k, 142);

    // Abort mid-row 2.
    fill(1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    start = 1'b1;
    k = 0;
    tick();
    start = 1'b0;
    while (!(w_row == 2'd2 && w_col == 5'd10) && k < 200) tick();
    chk("abort cycle", k, 79);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort w_row", 32'(w_row), 0);
    chk("abort w_col", 32'(w_col), 0);
    chk("abort x_addr", 32'(x_addr), 0);
    chk("abort out_row", 32'(out_row), 0);
    chk("abort out_data", 32'(out_data), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort no done", 32'(done), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("post-abort idle done", 32'(done), 0);
    chk("post-abort idle busy", 32'(busy), 0);
    run_vec("rerun", vt[4].exp, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
